md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_pkg.sv | 17 +
 rtl/md_busy_chk.sv | 20 ++
 rtl/md_issue_ctrl.sv | 60 ++++++
 tb/tb_md_issue_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: op codes, default latencies and FSM state shared by the md issue controller
package md_pkg;
  localparam int MUL_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MULT  = 4'd2,
    OP_DIVU  = 4'd3,
    OP_DIV   = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;
endpackage

// File: rtl/md_busy_chk.sv
// md_busy_chk: sticky flag raised when the FSM and the unit disagree about being busy
module md_busy_chk (
  input  logic clk,
  input  logic reset,
  input  logic in_busy,
  input  logic md_busy,
  input  logic md_start,
  output logic proto_err
);
  logic start_q, start_d, err_q, err_d;
  always_comb begin
    start_d = md_start;
    err_d = err_q | (in_busy & ~md_busy) | (~in_busy & md_busy & ~start_q);
  end
  always_ff @(posedge clk) begin
    start_q <= reset ? 1'b0 : start_d;
    err_q <= reset ? 1'b0 : err_d;
  end
  assign proto_err = err_q;
endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues mult/div/move ops to the HI/LO unit and stalls E while it is busy
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_CYC = MUL_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic        e_flush,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_start,
  output logic [4:0]  md_ctrl,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic        proto_err
);
  md_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic md_cls, mul_div, issue;
  always_comb begin
    md_cls = e_op inside {[OP_MULTU:OP_MTLO]};
    mul_div = e_op inside {[OP_MULTU:OP_DIV]};
    stall = ~reset & e_valid & ~e_flush & md_cls & (state_q == BUSY);
    issue = ~reset & e_valid & ~e_flush & ~stall;
    md_start = issue & mul_div;
    md_ctrl = (issue & md_cls) ? {1'b0, e_op} : 5'd0;
    mf_data = ~issue ? 32'd0 : (e_op == OP_MFHI) ? md_hi : (e_op == OP_MFLO) ? md_lo : 32'd0;
    state_d = md_start ? BUSY : (state_q == BUSY && cnt_q == 4'd1) ? IDLE : state_q;
    cnt_d = md_start ? ((e_op <= OP_MULT) ? 4'(MUL_CYC) : 4'(DIV_CYC)) :
            (state_q == BUSY) ? cnt_q - 4'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign md_a = e_rs;
  assign md_b = e_rt;
  md_busy_chk u_chk (
    .clk(clk),
    .reset(reset),
    .in_busy(state_q == BUSY),
    .md_busy(md_busy),
    .md_start(md_start),
    .proto_err(proto_err)
  );
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: randomized and directed checks of md_issue_ctrl against a timestamp-based model
module tb_md_issue_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0, reset = 1, e_valid = 0, e_flush = 0;
  logic [3:0] e_op = 0;
  logic [31:0] e_rs = 0, e_rt = 0;
  logic md_busy, md_start, stall, proto_err;
  logic [31:0] md_hi, md_lo, md_a, md_b, mf_data;
  logic [4:0] md_ctrl;
  always #5 clk = ~clk;
  md_issue_ctrl #(.MUL_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_flush(e_flush), .e_op(e_op),
    .e_rs(e_rs), .e_rt(e_rt), .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
    .md_start(md_start), .md_ctrl(md_ctrl), .md_a(md_a), .md_b(md_b),
    .stall(stall), .mf_data(mf_data), .proto_err(proto_err)
  );
  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] unit_result(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (c == 5'd1) return {32'd0, a} * {32'd0, b};
    if (c == 5'd2) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (c == 5'd3) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction
  int u_left = 0;
  logic kill_busy = 0, kill_req = 0;
  logic [31:0] u_hi = 0, u_lo = 0, s_a = 0, s_b = 0;
  logic s_reset = 0, s_start = 0;
  logic [4:0] s_ctrl = 0;
  assign md_busy = (u_left > 0) && !kill_busy;
  assign md_hi = u_hi;
  assign md_lo = u_lo;
  always @(negedge clk) begin
    s_reset = reset;
    s_start = md_start;
    s_ctrl = md_ctrl;
    s_a = md_a;
    s_b = md_b;
  end
  always begin
    @(posedge clk);
    #1;
    if (s_reset) u_left = 0;
    else if (s_start) begin
      u_left = (s_ctrl <= 5'd2) ? MC : DC;
      {u_hi, u_lo} = unit_result(s_ctrl, s_a, s_b);
    end else begin
      if (u_left > 0) u_left--;
      if (s_ctrl == 5'd7) u_hi = s_a;
      if (s_ctrl == 5'd8) u_lo = s_a;
    end
  end
  int cyc = 0, ready_at = 0;
  logic exp_err = 0, prev_start = 0, started = 0;
  logic m_cls, m_busy, m_stall, m_iss, m_start;
  logic [4:0] m_ctrl;
  logic [31:0] m_mf;
  always @(negedge clk) if (started) begin
    m_cls = e_op >= 4'd1 && e_op <= 4'd8;
    m_busy = cyc < ready_at;
    m_stall = !reset && e_valid && !e_flush && m_cls && m_busy;
    m_iss = !reset && e_valid && !e_flush && !m_stall;
    m_start = m_iss && e_op >= 4'd1 && e_op <= 4'd4;
    m_ctrl = (m_iss && m_cls) ? {1'b0, e_op} : 5'd0;
    m_mf = (m_iss && e_op == 4'd5) ? md_hi : (m_iss && e_op == 4'd6) ? md_lo : 32'd0;
    chk("stall", {31'd0, stall}, {31'd0, m_stall});
    chk("md_start", {31'd0, md_start}, {31'd0, m_start});
    chk("md_ctrl", {27'd0, md_ctrl}, {27'd0, m_ctrl});
    chk("mf_data", mf_data, m_mf);
    chk("md_a", md_a, e_rs);
    chk("md_b", md_b, e_rt);
    chk("proto_err", {31'd0, proto_err}, {31'd0, exp_err});
    if (reset) begin
      exp_err = 0;
      prev_start = 0;
      ready_at = 0;
    end else begin
      exp_err = exp_err | (m_busy && !md_busy) | (!m_busy && md_busy && !prev_start);
      prev_start = m_start;
      if (m_start) ready_at = cyc + 1 + ((e_op <= 4'd2) ? MC : DC);
    end
    cyc++;
  end
  task automatic cyc_in(input logic r, input logic v, input logic f, input logic [3:0] op,
                        input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    reset = r;
    e_valid = v;
    e_flush = f;
    e_op = op;
    e_rs = rs;
    e_rt = rt;
    kill_busy = kill_req;
    @(negedge clk);
    #1;
  endtask
  task automatic issue_wait(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            output int stalls, output int nz);
    stalls = 0;
    nz = 0;
    cyc_in(0, 1, 0, op, rs, rt);
    while (stall && stalls < 40) begin
      stalls++;
      if (md_ctrl != 5'd0 || md_start) nz++;
      cyc_in(0, 1, 0, op, rs, rt);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
  initial begin
    int st, nz;
    logic [3:0] op;
    logic [31:0] rs, rt;
    @(posedge clk);
    started = 1;
    cyc_in(1, 1, 0, 4'd2, 32'd3, 32'd4);
    chk("rst_start", {31'd0, md_start}, 32'd0);
    chk("rst_ctrl", {27'd0, md_ctrl}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, proto_err}, 32'd0);
    cyc_in(1, 1, 0, 4'd5, 32'd0, 32'd0);
    chk("rst_mf", mf_data, 32'd0);
    cyc_in(0, 1, 0, 4'd2, 32'hFFFF_FFFF, 32'd2);
    chk("mult_start", {31'd0, md_start}, 32'd1);
    chk("mult_ctrl", {27'd0, md_ctrl}, 32'd2);
    issue_wait(4'd5, 32'd0, 32'd0, st, nz);
    chk("mult_mfhi_stalls", st, 32'd5);
    chk("mult_mfhi", mf_data, 32'hFFFF_FFFF);
    issue_wait(4'd6, 32'd0, 32'd0, st, nz);
    chk("mult_mflo", mf_data, 32'hFFFF_FFFE);
    issue_wait(4'd4, 32'd7, 32'hFFFF_FFFE, st, nz);
    chk("div_issue_stalls", st, 32'd0);
    issue_wait(4'd6, 32'd0, 32'd0, st, nz);
    chk("div_mflo_stalls", st, 32'd10);
    chk("div_mflo", mf_data, 32'hFFFF_FFFD);
    issue_wait(4'd5, 32'd0, 32'd0, st, nz);
    chk("div_mfhi", mf_data, 32'd1);
    issue_wait(4'd1, 32'd3, 32'd4, st, nz);
    issue_wait(4'd7, 32'h1234, 32'd0, st, nz);
    chk("mthi_stalls", st, 32'd5);
    chk("mthi_ctrl_quiet", nz, 32'd0);
    chk("mthi_ctrl", {27'd0, md_ctrl}, 32'd7);
    issue_wait(4'd5, 32'd0, 32'd0, st, nz);
    chk("mthi_mfhi", mf_data, 32'h1234);
    issue_wait(4'd3, 32'd100, 32'd7, st, nz);
    repeat (3) cyc_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
    cyc_in(1, 0, 0, 4'd0, 32'd0, 32'd0);
    cyc_in(0, 1, 0, 4'd5, 32'd0, 32'd0);
    chk("rstbusy_stall", {31'd0, stall}, 32'd0);
    chk("rstbusy_ctrl", {27'd0, md_ctrl}, 32'd5);
    chk("rstbusy_err", {31'd0, proto_err}, 32'd0);
    cyc_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
    chk("rstbusy_err2", {31'd0, proto_err}, 32'd0);
    issue_wait(4'd2, 32'd5, 32'd6, st, nz);
    cyc_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
    kill_req = 1;
    cyc_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
    chk("kill_err_pre", {31'd0, proto_err}, 32'd0);
    cyc_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
    chk("kill_err", {31'd0, proto_err}, 32'd1);
    repeat (12) cyc_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
    chk("kill_err_held", {31'd0, proto_err}, 32'd1);
    kill_req = 0;
    cyc_in(1, 0, 0, 4'd0, 32'd0, 32'd0);
    cyc_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
    chk("kill_err_cleared", {31'd0, proto_err}, 32'd0);
    cyc_in(0, 1, 1, 4'd2, 32'd9, 32'd9);
    chk("flush_start", {31'd0, md_start}, 32'd0);
    chk("flush_ctrl", {27'd0, md_ctrl}, 32'd0);
    cyc_in(0, 1, 0, 4'd5, 32'd0, 32'd0);
    chk("flush_idle", {31'd0, stall}, 32'd0);
    cyc_in(0, 1, 0, 4'd12, 32'd0, 32'd0);
    chk("nonmd_ctrl", {27'd0, md_ctrl}, 32'd0);
    repeat (3000) begin
      op = ($urandom % 4 != 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
      rs = ($urandom % 16 == 0) ? 32'h8000_0000 : $urandom;
      rt = ($urandom % 16 == 0) ? 32'hFFFF_FFFF : $urandom;
      if (rt == 32'd0) rt = 32'd1;
      cyc_in($urandom % 250 == 0, $urandom % 4 != 0, $urandom % 8 == 0, op, rs, rt);
    end
    cyc_in(0, 0, 0, 4'd0, 32'd0, 32'd0);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
